// File: rtl/alu_taylor_calc_pkg.sv
// Shared ALU globals: function codes, Q2.16 constants and Taylor FSM types.
package alu_taylor_calc_pkg;

   // ALU function codes (9-bit selector)
   localparam logic [8:0] ALU_FUNC_NONE         = 9'h000;
   localparam logic [8:0] ALU_FUNC_ADD          = 9'h001;
   localparam logic [8:0] ALU_FUNC_SUB          = 9'h002;
   localparam logic [8:0] ALU_FUNC_MUL          = 9'h003;
   localparam logic [8:0] ALU_FUNC_EXP          = 9'h040;
   localparam logic [8:0] ALU_FUNC_SIN          = 9'h041;
   localparam logic [8:0] ALU_FUNC_COS          = 9'h042;
   localparam logic [8:0] ALU_FUNC_INV_1_PLUS_X = 9'h043;

   // Q2.16 fixed-point constants
   localparam int         Q16_W   = 18;
   localparam int         Q16_FRAC = 16;
   localparam logic [17:0] Q16_ONE = 18'h10000;
   localparam logic [17:0] Q16_MAX = 18'h1FFFF;
   localparam logic [17:0] Q16_MIN = 18'h20000;

   // Taylor evaluator sequencing states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_MUL_X = 3'd2,
      ST_MUL_C = 3'd3,
      ST_ACC   = 3'd4,
      ST_DONE  = 3'd5
   } taylor_state_t;

endpackage

// File: rtl/alu_q16_mul_sat.sv
// Combinational Q2.16 x Q2.16 multiply: full signed product, floor shift,
// saturation back to the 18-bit Q2.16 range.
module alu_q16_mul_sat
   import alu_taylor_calc_pkg::*;
(
   input  logic signed [17:0] i_a,
   input  logic signed [17:0] i_b,
   output logic signed [17:0] o_p
);

   localparam logic signed [35:0] LIM_HI = 36'sd131071;
   localparam logic signed [35:0] LIM_LO = -36'sd131072;

   logic signed [35:0] w_prod;
   logic signed [35:0] w_shift;

   // Multiply, drop the fraction with an arithmetic (floor) shift, clamp
   always_comb begin
      w_prod  = i_a * i_b;
      w_shift = w_prod >>> Q16_FRAC;
      if (w_shift > LIM_HI) begin
         o_p = Q16_MAX;
      end else if (w_shift < LIM_LO) begin
         o_p = Q16_MIN;
      end else begin
         o_p = w_shift[17:0];
      end
   end

endmodule

// File: rtl/alu_taylor_calc.sv
// Sequential Taylor-series evaluator: walks the coefficient table and
// accumulates a0 + sum(term_n) using one shared saturating multiplier.
module alu_taylor_calc
   import alu_taylor_calc_pkg::*;
#(
   parameter int NUM_TERMS = 11
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [8:0]  function_sel,
   input  logic [17:0] x,
   output logic        busy,
   output logic        done,
   output logic [17:0] result,
   output logic [8:0]  coef_function_sel,
   output logic [3:0]  coef_idx,
   input  logic [17:0] coef_deriv,
   input  logic [17:0] coef_a0
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_TERMS - 1);

   taylor_state_t      r_state;
   taylor_state_t      w_next;
   logic signed [17:0] r_x;
   logic [8:0]         r_func;
   logic [3:0]         r_n;
   logic signed [17:0] r_acc;
   logic signed [17:0] r_term;
   logic signed [17:0] r_result;
   logic signed [17:0] w_mul_b;
   logic signed [17:0] w_mul_p;
   logic signed [17:0] w_sum;

   // Saturating Q2.16 add via a 19-bit intermediate
   function automatic logic signed [17:0] sat_add(input logic signed [17:0] a,
                                                  input logic signed [17:0] b);
      logic signed [18:0] s;
      s = {a[17], a} + {b[17], b};
      if (s[18] != s[17]) begin
         return s[18] ? Q16_MIN : Q16_MAX;
      end
      return s[17:0];
   endfunction

   // Single multiplier; second operand is x in MUL_X, the table coefficient otherwise
   alu_q16_mul_sat u_mul (
      .i_a (r_term),
      .i_b (w_mul_b),
      .o_p (w_mul_p)
   );

   assign w_sum = sat_add(r_acc, r_term);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_next = ST_LOAD;
         ST_LOAD:  w_next = ST_MUL_X;
         ST_MUL_X: w_next = ST_MUL_C;
         ST_MUL_C: w_next = ST_ACC;
         ST_ACC:   w_next = (r_n == LAST_IDX) ? ST_DONE : ST_MUL_X;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Outputs and operand mux decoded from the current state
   always_comb begin
      busy              = (r_state != ST_IDLE);
      done              = (r_state == ST_DONE);
      result            = (r_state == ST_DONE) ? r_acc : r_result;
      coef_function_sel = (r_state == ST_IDLE) ? 9'd0 : r_func;
      coef_idx          = (r_state == ST_IDLE || r_state == ST_LOAD) ? 4'd0 : r_n;
      w_mul_b           = (r_state == ST_MUL_X) ? r_x : coef_deriv;
   end

   // Datapath: operand capture, term/accumulator updates, result hold
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_x      <= '0;
         r_func   <= '0;
         r_n      <= '0;
         r_acc    <= '0;
         r_term   <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_n <= '0;
               if (start) begin
                  r_x    <= x;
                  r_func <= function_sel;
               end
            end
            ST_LOAD: begin
               r_acc  <= coef_a0;
               r_term <= coef_a0;
            end
            ST_MUL_X, ST_MUL_C: begin
               r_term <= w_mul_p;
            end
            ST_ACC: begin
               r_acc <= w_sum;
               if (r_n != LAST_IDX) r_n <= r_n + 4'd1;
            end
            ST_DONE: begin
               r_result <= r_acc;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_taylor_calc.sv
// Directed bench for alu_taylor_calc with a small behavioural coefficient table.
module tb_alu_taylor_calc;
   import alu_taylor_calc_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [8:0]  function_sel;
   logic [17:0] x;
   logic        busy;
   logic        done;
   logic [17:0] result;
   logic [8:0]  coef_function_sel;
   logic [3:0]  coef_idx;
   logic [17:0] coef_deriv;
   logic [17:0] coef_a0;

   int n_vec  = 0;
   int n_miss = 0;

   alu_taylor_calc #(.NUM_TERMS(11)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .start             (start),
      .function_sel      (function_sel),
      .x                 (x),
      .busy              (busy),
      .done              (done),
      .result            (result),
      .coef_function_sel (coef_function_sel),
      .coef_idx          (coef_idx),
      .coef_deriv        (coef_deriv),
      .coef_a0           (coef_a0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Table: INV_1_PLUS_X -> a0 = 1.0, deriv = 0.5, -0.5 x9, 0; anything else zeros
   always_comb begin
      coef_a0    = 18'h00000;
      coef_deriv = 18'h00000;
      if (coef_function_sel == ALU_FUNC_INV_1_PLUS_X) begin
         coef_a0 = Q16_ONE;
         if (coef_idx == 4'd0)      coef_deriv = 18'h08000;
         else if (coef_idx <= 4'd9) coef_deriv = 18'h38000;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // One evaluation; optional stray start at pulse_cyc, optional reset at rst_cyc
   task automatic run(input string name, input logic [8:0] f, input logic [17:0] xv,
                      input logic [17:0] exp_res, input bit chk_idx,
                      input int pulse_cyc, input int rst_cyc);
      int cyc;
      int ndone;
      int done_cyc;
      bit aborted;
      aborted  = (rst_cyc > 0);
      ndone    = 0;
      done_cyc = -1;
      @(negedge clk);
      function_sel = f;
      x            = xv;
      start        = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      x     = 18'h00000;
      cyc   = 1;
      while (cyc < 45) begin
         if (cyc == 1) check({name, "_busy_c1"}, 32'(busy), 32'd1);
         if (cyc == 2) check({name, "_fsel_c2"}, 32'(coef_function_sel), 32'(f));
         if (chk_idx && cyc >= 2 && cyc <= 34)
            check({name, "_idx"}, 32'(coef_idx), 32'((cyc - 2) / 3));
         if (done) begin
            ndone++;
            done_cyc = cyc;
            check({name, "_result"}, 32'(result), 32'(exp_res));
            check({name, "_busy_done"}, 32'(busy), 32'd1);
         end
         if (!aborted && cyc == 37) begin
            check({name, "_hold"}, 32'(result), 32'(exp_res));
            check({name, "_idle_busy"}, 32'(busy), 32'd0);
            check({name, "_idle_fsel"}, 32'(coef_function_sel), 32'd0);
            check({name, "_idle_idx"}, 32'(coef_idx), 32'd0);
         end
         start = (cyc == pulse_cyc);
         if (cyc == pulse_cyc) x = 18'h00000;
         if (cyc == rst_cyc) begin
            reset_n = 1'b0;
            #1;
            check({name, "_rst_busy"}, 32'(busy), 32'd0);
            check({name, "_rst_idx"}, 32'(coef_idx), 32'd0);
         end
         if (rst_cyc > 0 && cyc == rst_cyc + 2) reset_n = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      if (aborted) begin
         check({name, "_ndone"}, 32'(ndone), 32'd0);
         check({name, "_res_clr"}, 32'(result), 32'd0);
      end else begin
         check({name, "_ndone"}, 32'(ndone), 32'd1);
         check({name, "_latency"}, 32'(done_cyc), 32'd35);
      end
   endtask

   initial begin
      reset_n      = 1'b0;
      start        = 1'b1;
      function_sel = ALU_FUNC_INV_1_PLUS_X;
      x            = 18'h10000;
      repeat (4) begin
         @(posedge clk); #1;
         check("rst_busy",   32'(busy), 32'd0);
         check("rst_done",   32'(done), 32'd0);
         check("rst_result", 32'(result), 32'd0);
         check("rst_idx",    32'(coef_idx), 32'd0);
         check("rst_fsel",   32'(coef_function_sel), 32'd0);
      end
      start = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("post_rst_busy", 32'(busy), 32'd0);

      run("inv_x0",    ALU_FUNC_INV_1_PLUS_X, 18'h00000, 18'h10000, 1'b0, -1, -1);
      run("inv_x1",    ALU_FUNC_INV_1_PLUS_X, 18'h10000, 18'h15540, 1'b0, -1, -1);
      run("inv_xm2",   ALU_FUNC_INV_1_PLUS_X, 18'h20000, 18'h20000, 1'b0, -1, -1);
      run("unsup",     ALU_FUNC_NONE,         18'h0ABCD, 18'h00000, 1'b1, -1, -1);
      run("stray_st",  ALU_FUNC_INV_1_PLUS_X, 18'h10000, 18'h15540, 1'b0, 10, -1);
      run("abort",     ALU_FUNC_INV_1_PLUS_X, 18'h10000, 18'h15540, 1'b0, -1, 20);
      run("after_rst", ALU_FUNC_INV_1_PLUS_X, 18'h10000, 18'h15540, 1'b1, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   // Hard stop in case the sequence above stalls
   initial begin
      #200000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1);
   end

endmodule
